fetch_buf: RTL and testbench

FETCH_BUF -- requirements
Module: fetch_buf

---
 rtl/fetch_buf.sv | 105 ++++++++++
 tb/tb_fetch_buf.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buf.sv
// Instruction fetch buffer: issues sequential fetches and queues the responses in
// order for decode; a redirect flushes the queue and drops responses still in flight.
module fetch_buf #(
    parameter logic [31:0] RESET_ADDR = 32'h00000000,
    parameter int          DEPTH      = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_halt,
    output logic        o_imem_req,
    output logic [31:0] o_imem_raddr,
    input  logic        i_imem_ack,
    input  logic        i_imem_rvld,
    input  logic [31:0] i_imem_rdata,
    output logic        o_vld,
    input  logic        i_rdy,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_nxt_pc
);

    localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW   = 16;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [31:0]   r_pc;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW-1:0] r_fptr;
    logic [AW:0]   r_cnt;
    logic [AW:0]   r_outs;
    logic [CW-1:0] r_disc;
    logic [31:0]   r_q_pc   [DEPTH];
    logic [31:0]   r_q_inst [DEPTH];

    logic w_acc;
    logic w_pop;
    logic w_drop;
    logic w_fill;
    logic w_rsp;
    logic w_unused_pc_lsb;

    assign w_unused_pc_lsb = &{1'b0, i_redirect_pc[1:0]};

    assign o_imem_req   = !i_rst && !i_redirect && !i_halt && (r_cnt < FULL);
    assign o_imem_raddr = r_pc;
    // Entries fill strictly in order, so the head is filled whenever any entry is.
    assign o_vld        = (r_cnt > r_outs);
    assign o_inst       = r_q_inst[r_head];
    assign o_pc         = r_q_pc[r_head];
    assign o_nxt_pc     = r_q_pc[r_head] + 32'd4;

    assign w_acc  = o_imem_req && i_imem_ack;
    assign w_pop  = o_vld && i_rdy;
    assign w_drop = i_imem_rvld && (r_disc != '0);
    assign w_fill = i_imem_rvld && (r_disc == '0) && (r_outs != '0);
    assign w_rsp  = w_drop || w_fill;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc   <= RESET_ADDR;
            r_head <= '0;
            r_tail <= '0;
            r_fptr <= '0;
            r_cnt  <= '0;
            r_outs <= '0;
            r_disc <= '0;
        end else if (i_redirect) begin
            // Everything still in flight, old stale or newly live, must be dropped.
            r_pc   <= {i_redirect_pc[31:2], 2'b00};
            r_head <= '0;
            r_tail <= '0;
            r_fptr <= '0;
            r_cnt  <= '0;
            r_outs <= '0;
            r_disc <= r_disc + CW'(r_outs) - CW'(w_rsp);
        end else begin
            if (w_acc) begin
                r_pc   <= r_pc + 32'd4;
                r_tail <= r_tail + AW'(1);
            end
            if (w_fill) begin
                r_fptr <= r_fptr + AW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            r_cnt  <= r_cnt + (AW+1)'(w_acc) - (AW+1)'(w_pop);
            r_outs <= r_outs + (AW+1)'(w_acc) - (AW+1)'(w_fill);
            r_disc <= r_disc - CW'(w_drop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_acc) begin
            r_q_pc[r_tail] <= r_pc;
        end
        if (w_fill) begin
            r_q_inst[r_fptr] <= i_imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_buf.sv
// Bench for fetch_buf: directed vector table, hand-built redirect/wrap sequences and
// randomized traffic checked against a transaction-level queue model.
`timescale 1ns/1ps
module tb_fetch_buf;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, redirect, halt, ack, rvld, rdy;
    logic [31:0] rpc, rdata;
    logic        req, vld;
    logic [31:0] raddr, inst, pc, npc;

    logic        b_rst, b_redirect, b_halt, b_ack, b_rvld, b_rdy;
    logic [31:0] b_rpc, b_rdata;
    logic        b_req, b_vld;
    logic [31:0] b_raddr, b_inst, b_pc, b_npc;

    fetch_buf #(.RESET_ADDR(32'h00000000), .DEPTH(DEPTH)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_redirect(redirect), .i_redirect_pc(rpc),
        .i_halt(halt), .o_imem_req(req), .o_imem_raddr(raddr), .i_imem_ack(ack),
        .i_imem_rvld(rvld), .i_imem_rdata(rdata), .o_vld(vld), .i_rdy(rdy),
        .o_inst(inst), .o_pc(pc), .o_nxt_pc(npc)
    );

    fetch_buf #(.RESET_ADDR(32'hFFFFFFF8), .DEPTH(DEPTH)) u_dut_wrap (
        .i_clk(clk), .i_rst(b_rst), .i_redirect(b_redirect), .i_redirect_pc(b_rpc),
        .i_halt(b_halt), .o_imem_req(b_req), .o_imem_raddr(b_raddr), .i_imem_ack(b_ack),
        .i_imem_rvld(b_rvld), .i_imem_rdata(b_rdata), .o_vld(b_vld), .i_rdy(b_rdy),
        .o_inst(b_inst), .o_pc(b_pc), .o_nxt_pc(b_npc)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ifun(input logic [31:0] a);
        return (a ^ 32'h13579BDF) + 32'h00010001;
    endfunction

    task automatic drv(input logic r, input logic d, input logic [31:0] p, input logic h,
                       input logic k, input logic v, input logic [31:0] dt, input logic y);
        @(negedge clk);
        rst = r; redirect = d; rpc = p; halt = h; ack = k; rvld = v; rdata = dt; rdy = y;
        #1;
    endtask

    typedef struct {
        logic        rst, redir;
        logic [31:0] rpc;
        logic        halt, ack, rvld;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_raddr;
        logic        e_vld;
        logic [31:0] e_pc, e_inst;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic d, input logic [31:0] p,
                                input logic h, input logic k, input logic v,
                                input logic [31:0] dt, input logic y, input logic er,
                                input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic [31:0] ei);
        vec_t t;
        t.rst = r; t.redir = d; t.rpc = p; t.halt = h; t.ack = k; t.rvld = v;
        t.rdata = dt; t.rdy = y; t.e_req = er; t.e_raddr = ea; t.e_vld = ev;
        t.e_pc = ep; t.e_inst = ei;
        return t;
    endfunction

    typedef struct { logic [31:0] pc; logic f; logic [31:0] inst; } ent_t;
    typedef struct { logic [31:0] a; int ep; int rdy; } mem_t;
    ent_t        mq[$];
    mem_t        mm[$];
    logic [31:0] m_pc;
    int          ep  = 0;
    int          cyc = 0;

    vec_t tbl[16];

    initial begin
        logic        pa;
        logic [31:0] pad;
        rst = 1; redirect = 0; rpc = 0; halt = 0; ack = 0; rvld = 0; rdata = 0; rdy = 0;
        b_rst = 1; b_redirect = 0; b_rpc = 0; b_halt = 0; b_ack = 1; b_rvld = 0;
        b_rdata = 0; b_rdy = 1;

        // Fill to DEPTH with decode stalled, one pop, then a redirect to an unaligned target.
        tbl[0]  = mk(1,0,0,    0,0,0,0,          0, 0,32'h000,0,32'h000,0);
        tbl[1]  = mk(0,0,0,    0,1,0,0,          0, 1,32'h000,0,32'h000,0);
        tbl[2]  = mk(0,0,0,    0,1,1,ifun(0),    0, 1,32'h004,0,32'h000,0);
        tbl[3]  = mk(0,0,0,    0,1,1,ifun(4),    0, 1,32'h008,1,32'h000,ifun(0));
        tbl[4]  = mk(0,0,0,    0,1,1,ifun(8),    0, 1,32'h00C,1,32'h000,ifun(0));
        tbl[5]  = mk(0,0,0,    0,1,1,ifun(12),   0, 0,32'h010,1,32'h000,ifun(0));
        tbl[6]  = mk(0,0,0,    0,1,0,0,          0, 0,32'h010,1,32'h000,ifun(0));
        tbl[7]  = mk(0,0,0,    0,1,0,0,          1, 0,32'h010,1,32'h000,ifun(0));
        tbl[8]  = mk(0,0,0,    0,1,0,0,          0, 1,32'h010,1,32'h004,ifun(4));
        tbl[9]  = mk(0,0,0,    0,1,0,0,          0, 0,32'h014,1,32'h004,ifun(4));
        tbl[10] = mk(0,1,32'h103,0,1,0,0,        0, 0,32'h014,1,32'h004,ifun(4));
        tbl[11] = mk(0,0,0,    0,0,1,ifun(16),   0, 1,32'h100,0,32'h000,0);
        tbl[12] = mk(0,0,0,    0,1,0,0,          0, 1,32'h100,0,32'h000,0);
        tbl[13] = mk(0,0,0,    0,0,1,ifun(256),  0, 1,32'h104,0,32'h000,0);
        tbl[14] = mk(0,0,0,    0,0,0,0,          1, 1,32'h104,1,32'h100,ifun(256));
        tbl[15] = mk(0,0,0,    1,0,0,0,          0, 0,32'h104,0,32'h000,0);

        for (int i = 0; i < 16; i++) begin
            drv(tbl[i].rst, tbl[i].redir, tbl[i].rpc, tbl[i].halt, tbl[i].ack,
                tbl[i].rvld, tbl[i].rdata, tbl[i].rdy);
            chk($sformatf("tbl%0d req", i), {31'd0, req}, {31'd0, tbl[i].e_req});
            chk($sformatf("tbl%0d raddr", i), raddr, tbl[i].e_raddr);
            chk($sformatf("tbl%0d vld", i), {31'd0, vld}, {31'd0, tbl[i].e_vld});
            if (tbl[i].e_vld) begin
                chk($sformatf("tbl%0d pc", i), pc, tbl[i].e_pc);
                chk($sformatf("tbl%0d inst", i), inst, tbl[i].e_inst);
                chk($sformatf("tbl%0d nxt_pc", i), npc, tbl[i].e_pc + 32'd4);
            end
        end

        // Two stale requests, redirect, one more issued, second redirect: three drops.
        drv(1,0,0,0,0,0,0,0);
        chk("dr reset vld", {31'd0, vld}, 32'd0);
        drv(0,0,0,0,1,0,0,0);
        drv(0,0,0,0,1,0,0,0);
        chk("dr raddr4", raddr, 32'h4);
        drv(0,1,32'h200,0,0,0,0,0);
        drv(0,0,0,0,1,0,0,0);
        chk("dr raddr200", raddr, 32'h200);
        drv(0,1,32'h300,0,0,0,0,0);
        chk("dr redirect req", {31'd0, req}, 32'd0);
        drv(0,0,0,0,0,1,ifun(0),0);
        chk("dr raddr300", raddr, 32'h300);
        drv(0,0,0,0,0,1,ifun(4),0);
        chk("dr drop1 vld", {31'd0, vld}, 32'd0);
        drv(0,0,0,0,0,1,ifun(32'h200),0);
        chk("dr drop2 vld", {31'd0, vld}, 32'd0);
        drv(0,0,0,0,1,0,0,0);
        chk("dr drop3 vld", {31'd0, vld}, 32'd0);
        chk("dr req300", {31'd0, req}, 32'd1);
        drv(0,0,0,0,0,1,ifun(32'h300),0);
        chk("dr pre-fill vld", {31'd0, vld}, 32'd0);
        drv(0,0,0,0,0,0,0,1);
        chk("dr vld", {31'd0, vld}, 32'd1);
        chk("dr pc", pc, 32'h300);
        chk("dr inst", inst, ifun(32'h300));

        // Address wrap from a high reset address, streaming one per cycle.
        #1;
        chk("wrap reset raddr", b_raddr, 32'hFFFFFFF8);
        chk("wrap reset req", {31'd0, b_req}, 32'd0);
        pa = 0; pad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            b_rst = 0; b_rvld = pa; b_rdata = ifun(pad);
            #1;
            chk($sformatf("wrap%0d req", c), {31'd0, b_req}, 32'd1);
            chk($sformatf("wrap%0d raddr", c), b_raddr, 32'hFFFFFFF8 + 32'(4 * c));
            chk($sformatf("wrap%0d vld", c), {31'd0, b_vld}, {31'd0, c >= 2});
            if (c >= 2) begin
                chk($sformatf("wrap%0d pc", c), b_pc, 32'hFFFFFFF8 + 32'(4 * (c - 2)));
                chk($sformatf("wrap%0d nxt_pc", c), b_npc, 32'hFFFFFFFC + 32'(4 * (c - 2)));
                chk($sformatf("wrap%0d inst", c), b_inst, ifun(32'hFFFFFFF8 + 32'(4 * (c - 2))));
            end
            pa = b_req && b_ack;
            pad = b_raddr;
        end

        // Randomized traffic against the queue model.
        for (int i = 0; i < 3000; i++) begin
            logic e_req, e_vld, acc, pop, live, done;
            mem_t me;
            @(negedge clk);
            if (i == 0 || $urandom_range(0, 399) == 0) begin
                rst = 1; redirect = 0; rvld = 0; ack = 0; rdy = 0; halt = 0;
                #1;
                chk("rnd async reset req", {31'd0, req}, 32'd0);
                chk("rnd async reset vld", {31'd0, vld}, 32'd0);
                chk("rnd async reset raddr", raddr, 32'h0);
                mq.delete(); mm.delete(); m_pc = 32'h0;
                cyc++;
                continue;
            end
            rst = 0;
            redirect = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            halt = ($urandom_range(0, 7) == 0);
            ack = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 9) < 7);
            rvld = 0; rdata = $urandom;
            if (mm.size() > 0 && mm[0].rdy <= cyc && $urandom_range(0, 4) != 0) begin
                rvld = 1; rdata = ifun(mm[0].a);
            end else if (mm.size() == 0 && $urandom_range(0, 29) == 0) begin
                rvld = 1;
            end
            #1;
            e_req = !redirect && !halt && (mq.size() < DEPTH);
            e_vld = (mq.size() > 0) && mq[0].f;
            chk("rnd req", {31'd0, req}, {31'd0, e_req});
            chk("rnd raddr", raddr, m_pc);
            chk("rnd vld", {31'd0, vld}, {31'd0, e_vld});
            if (e_vld) begin
                chk("rnd pc", pc, mq[0].pc);
                chk("rnd inst", inst, mq[0].inst);
                chk("rnd nxt_pc", npc, mq[0].pc + 32'd4);
            end
            acc = e_req && ack;
            pop = e_vld && rdy;
            live = 0;
            if (rvld && mm.size() > 0) begin
                me = mm.pop_front();
                live = (me.ep == ep);
            end
            if (redirect) begin
                mq.delete();
                m_pc = {rpc[31:2], 2'b00};
                ep++;
            end else begin
                done = 0;
                if (live) begin
                    foreach (mq[k]) begin
                        if (!done && !mq[k].f) begin
                            mq[k].f = 1; mq[k].inst = rdata; done = 1;
                        end
                    end
                end
                if (pop) void'(mq.pop_front());
                if (acc) begin
                    mq.push_back('{pc: m_pc, f: 1'b0, inst: 32'h0});
                    mm.push_back('{a: m_pc, ep: ep, rdy: cyc + 1 + int'($urandom_range(0, 3))});
                    m_pc = m_pc + 32'd4;
                end
            end
            cyc++;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
